// File: rtl/chu_gcd_pkg.sv
// Shared constants for the Avalon-MM GCD accelerator: register map,
// CTRL/STATUS bit positions and the engine state encoding.
package chu_gcd_pkg;

  typedef logic [2:0] reg_addr_t;

  localparam reg_addr_t ADDR_A      = 3'd0;
  localparam reg_addr_t ADDR_B      = 3'd1;
  localparam reg_addr_t ADDR_CTRL   = 3'd2;
  localparam reg_addr_t ADDR_STATUS = 3'd3;
  localparam reg_addr_t ADDR_RESULT = 3'd4;
  localparam reg_addr_t ADDR_CYCLES = 3'd5;

  localparam int CTRL_START    = 0;
  localparam int CTRL_CLR_DONE = 1;
  localparam int CTRL_IRQ_EN   = 2;
  localparam int CTRL_CLR_ERR  = 3;

  localparam int STAT_READY  = 0;
  localparam int STAT_DONE   = 1;
  localparam int STAT_IRQ_EN = 2;
  localparam int STAT_ERR    = 3;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_OP   = 1'b1;

endpackage

// File: rtl/chu_avalon_gcdx_if.sv
// Avalon-MM slave bus bundle for the GCD accelerator.
interface chu_avalon_gcdx_if;
  // Zero-wait-state slave: a write is taken on every rising clk where
  // chipselect && write; readdata follows address combinationally, read has
  // no side effect, and there is no waitrequest (the slave is always ready).
  logic [2:0]  gcd_address;
  logic        gcd_chipselect;
  logic        gcd_write;
  logic        gcd_read;
  logic [31:0] gcd_writedata;
  logic [31:0] gcd_readdata;
  logic        gcd_irq;

  modport master (
    output gcd_address, gcd_chipselect, gcd_write, gcd_read, gcd_writedata,
    input  gcd_readdata, gcd_irq
  );

  modport slave (
    input  gcd_address, gcd_chipselect, gcd_write, gcd_read, gcd_writedata,
    output gcd_readdata, gcd_irq
  );
endinterface

// File: rtl/chu_gcd_core.sv
// Binary (Stein) GCD engine: one reduction rule per OP cycle, common factors
// of two are counted in n and restored by shifting the result on completion.
module chu_gcd_core
  import chu_gcd_pkg::*;
#(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         start,
  input  logic [W-1:0] a_in,
  input  logic [W-1:0] b_in,
  output logic         ready,
  output logic         done_tick,
  output logic [W-1:0] r
);

  localparam int NW = $clog2(W + 1);

  logic [0:0]    r_state;
  logic [W-1:0]  r_a;
  logic [W-1:0]  r_b;
  logic [NW-1:0] r_n;

  logic [W-1:0]  w_a_nxt;
  logic [W-1:0]  w_b_nxt;
  logic [W-1:0]  w_sel;
  logic [NW-1:0] w_n_nxt;
  logic          w_done;

  always_comb begin
    w_a_nxt = r_a;
    w_b_nxt = r_b;
    w_n_nxt = r_n;
    w_sel   = r_a;
    w_done  = 1'b0;
    if (r_a == '0) begin
      w_done = 1'b1;
      w_sel  = r_b;
    end else if (r_b == '0) begin
      w_done = 1'b1;
    end else if (r_a == r_b) begin
      w_done = 1'b1;
    end else if (!r_a[0] && !r_b[0]) begin
      w_a_nxt = r_a >> 1;
      w_b_nxt = r_b >> 1;
      w_n_nxt = r_n + 1'b1;
    end else if (!r_a[0]) begin
      w_a_nxt = r_a >> 1;
    end else if (!r_b[0]) begin
      w_b_nxt = r_b >> 1;
    end else if (r_a > r_b) begin
      w_a_nxt = r_a - r_b;
    end else begin
      w_b_nxt = r_b - r_a;
    end
  end

  assign ready     = (r_state == ST_IDLE);
  assign done_tick = (r_state == ST_OP) && w_done;
  assign r         = w_sel << r_n;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= ST_IDLE;
      r_a     <= '0;
      r_b     <= '0;
      r_n     <= '0;
    end else if (r_state == ST_IDLE) begin
      if (start) begin
        r_a     <= a_in;
        r_b     <= b_in;
        r_n     <= '0;
        r_state <= ST_OP;
      end
    end else if (w_done) begin
      r_state <= ST_IDLE;
    end else begin
      r_a <= w_a_nxt;
      r_b <= w_b_nxt;
      r_n <= w_n_nxt;
    end
  end

endmodule

// File: rtl/chu_avalon_gcdx.sv
// Avalon-MM wrapper around chu_gcd_core: register file, sticky flags,
// OP-cycle counter and level interrupt.
module chu_avalon_gcdx
  import chu_gcd_pkg::*;
#(
  parameter int W  = 32,
  parameter int CW = 16
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [2:0]  gcd_address,
  input  logic        gcd_chipselect,
  input  logic        gcd_write,
  input  logic        gcd_read,
  input  logic [31:0] gcd_writedata,
  output logic [31:0] gcd_readdata,
  output logic        gcd_irq
);

  logic [W-1:0]  r_a;
  logic [W-1:0]  r_b;
  logic [W-1:0]  r_result;
  logic [CW-1:0] r_cycles;
  logic          r_done;
  logic          r_err;
  logic          r_irq_en;

  logic          w_we;
  logic          w_wr_ctrl;
  logic          w_start;
  logic          w_ready;
  logic          w_done_tick;
  logic [W-1:0]  w_r;
  logic          w_unused;

  assign w_we      = gcd_chipselect && gcd_write;
  assign w_wr_ctrl = w_we && (gcd_address == ADDR_CTRL);
  assign w_start   = w_wr_ctrl && gcd_writedata[CTRL_START];
  // Read strobe only qualifies the access; data is decoded from the address.
  assign w_unused  = gcd_read ^ (^gcd_writedata);

  chu_gcd_core #(.W(W)) u_core (
    .clk       (clk),
    .reset_n   (reset_n),
    .start     (w_start),
    .a_in      (r_a),
    .b_in      (r_b),
    .ready     (w_ready),
    .done_tick (w_done_tick),
    .r         (w_r)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_a      <= '0;
      r_b      <= '0;
      r_result <= '0;
      r_cycles <= '0;
      r_done   <= 1'b0;
      r_err    <= 1'b0;
      r_irq_en <= 1'b0;
    end else begin
      if (w_we && gcd_address == ADDR_A) r_a <= gcd_writedata[W-1:0];
      if (w_we && gcd_address == ADDR_B) r_b <= gcd_writedata[W-1:0];
      if (w_wr_ctrl) r_irq_en <= gcd_writedata[CTRL_IRQ_EN];
      if (w_done_tick) r_result <= w_r;

      if (w_start && w_ready) r_cycles <= '0;
      else if (!w_ready && r_cycles != {CW{1'b1}}) r_cycles <= r_cycles + 1'b1;

      // A completing computation wins over a simultaneous clear-done.
      if (w_start && w_ready) r_done <= 1'b0;
      else if (w_done_tick) r_done <= 1'b1;
      else if (w_wr_ctrl && gcd_writedata[CTRL_CLR_DONE]) r_done <= 1'b0;

      if (w_start && !w_ready) r_err <= 1'b1;
      else if (w_wr_ctrl && gcd_writedata[CTRL_CLR_ERR]) r_err <= 1'b0;
    end
  end

  always_comb begin
    gcd_readdata = '0;
    case (gcd_address)
      ADDR_A:      gcd_readdata = 32'(r_a);
      ADDR_B:      gcd_readdata = 32'(r_b);
      ADDR_STATUS: begin
        gcd_readdata[STAT_READY]  = w_ready;
        gcd_readdata[STAT_DONE]   = r_done;
        gcd_readdata[STAT_IRQ_EN] = r_irq_en;
        gcd_readdata[STAT_ERR]    = r_err;
      end
      ADDR_RESULT: gcd_readdata = 32'(r_result);
      ADDR_CYCLES: gcd_readdata = 32'(r_cycles);
      default:     gcd_readdata = '0;
    endcase
  end

  assign gcd_irq = r_done && r_irq_en;

endmodule

// File: tb/tb_chu_avalon_gcdx.sv
// Bench for chu_avalon_gcdx: vector table, hand-written corner sequences and
// random operands checked against a behavioural GCD model.
module tb_chu_avalon_gcdx;
  import chu_gcd_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  chu_avalon_gcdx_if bus32 ();
  chu_avalon_gcdx_if bus8 ();

  chu_avalon_gcdx #(.W(32), .CW(16)) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .gcd_address    (bus32.gcd_address),
    .gcd_chipselect (bus32.gcd_chipselect),
    .gcd_write      (bus32.gcd_write),
    .gcd_read       (bus32.gcd_read),
    .gcd_writedata  (bus32.gcd_writedata),
    .gcd_readdata   (bus32.gcd_readdata),
    .gcd_irq        (bus32.gcd_irq)
  );

  chu_avalon_gcdx #(.W(8), .CW(8)) dut8 (
    .clk            (clk),
    .reset_n        (reset_n),
    .gcd_address    (bus8.gcd_address),
    .gcd_chipselect (bus8.gcd_chipselect),
    .gcd_write      (bus8.gcd_write),
    .gcd_read       (bus8.gcd_read),
    .gcd_writedata  (bus8.gcd_writedata),
    .gcd_readdata   (bus8.gcd_readdata),
    .gcd_irq        (bus8.gcd_irq)
  );

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_fail   = 0;
  logic [31:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [31:0] ref_gcd(input logic [31:0] a_i, input logic [31:0] b_i);
    longint unsigned a = a_i;
    longint unsigned b = b_i;
    longint unsigned t;
    while (b != 0) begin
      t = a % b;
      a = b;
      b = t;
    end
    return a[31:0];
  endfunction

  function automatic int ref_cycles(input logic [31:0] a_i, input logic [31:0] b_i);
    longint unsigned a = a_i;
    longint unsigned b = b_i;
    int cyc = 0;
    while (1) begin
      cyc++;
      if (a == 0 || b == 0 || a == b) return cyc;
      if (a % 2 == 0 && b % 2 == 0) begin a = a / 2; b = b / 2; end
      else if (a % 2 == 0) a = a / 2;
      else if (b % 2 == 0) b = b / 2;
      else if (a > b) a = a - b;
      else b = b - a;
    end
  endfunction

  // ---------------- driver tasks ----------------
  task automatic idle_bus();
    bus32.gcd_chipselect = 1'b0; bus32.gcd_write = 1'b0; bus32.gcd_read = 1'b0;
    bus8.gcd_chipselect  = 1'b0; bus8.gcd_write  = 1'b0; bus8.gcd_read  = 1'b0;
  endtask

  task automatic bus_wr(input bit sel8, input logic [2:0] addr, input logic [31:0] data);
    @(negedge clk);
    if (sel8) begin
      bus8.gcd_address = addr; bus8.gcd_writedata = data;
      bus8.gcd_chipselect = 1'b1; bus8.gcd_write = 1'b1;
    end else begin
      bus32.gcd_address = addr; bus32.gcd_writedata = data;
      bus32.gcd_chipselect = 1'b1; bus32.gcd_write = 1'b1;
    end
    @(posedge clk);
    #1;
    idle_bus();
  endtask

  task automatic bus_rd(input bit sel8, input logic [2:0] addr, output logic [31:0] data);
    @(negedge clk);
    if (sel8) begin
      bus8.gcd_address = addr; bus8.gcd_chipselect = 1'b1; bus8.gcd_read = 1'b1;
    end else begin
      bus32.gcd_address = addr; bus32.gcd_chipselect = 1'b1; bus32.gcd_read = 1'b1;
    end
    #1;
    data = sel8 ? bus8.gcd_readdata : bus32.gcd_readdata;
    idle_bus();
  endtask

  task automatic wait_ready(input bit sel8, input string name);
    logic [31:0] s;
    bit got = 1'b0;
    int polls = 0;
    for (int i = 0; i < 300 && !got; i++) begin
      bus_rd(sel8, ADDR_STATUS, s);
      polls++;
      if (s[STAT_READY]) got = 1'b1;
    end
    if (!got) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s timeout: ready 0 after %0d polls, required 1", name, polls);
    end
  endtask

  task automatic run_gcd(input bit sel8, input logic [31:0] a, input logic [31:0] b,
                         input string name, output logic [31:0] res, output logic [31:0] cyc);
    bus_wr(sel8, ADDR_A, a);
    bus_wr(sel8, ADDR_B, b);
    bus_wr(sel8, ADDR_CTRL, 32'h1);
    wait_ready(sel8, name);
    bus_rd(sel8, ADDR_RESULT, res);
    bus_rd(sel8, ADDR_CYCLES, cyc);
  endtask

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    logic [31:0] cyc;
  } vec_t;

  vec_t vecs[8];

  // ---------------- test ----------------
  initial begin
    logic [31:0] rd, res, cyc, ra, rb;

    vecs[0] = '{a: 32'd36, b: 32'd24, res: 32'd12, cyc: 32'd6};
    vecs[1] = '{a: 32'd0,  b: 32'd0,  res: 32'd0,  cyc: 32'd1};
    vecs[2] = '{a: 32'd0,  b: 32'd5,  res: 32'd5,  cyc: 32'd1};
    vecs[3] = '{a: 32'd7,  b: 32'd0,  res: 32'd7,  cyc: 32'd1};
    vecs[4] = '{a: 32'd9,  b: 32'd9,  res: 32'd9,  cyc: 32'd1};
    vecs[5] = '{a: 32'd12, b: 32'd18, res: 32'd6,  cyc: 32'd5};
    vecs[6] = '{a: 32'd5,  b: 32'd3,  res: 32'd1,  cyc: 32'd5};
    vecs[7] = '{a: 32'd64, b: 32'd8,  res: 32'd8,  cyc: 32'd7};

    bus32.gcd_address = '0; bus32.gcd_writedata = '0;
    bus8.gcd_address  = '0; bus8.gcd_writedata  = '0;
    idle_bus();
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;

    // Reset state
    bus_rd(0, ADDR_STATUS, rd); check("reset_status", rd, 32'h1);
    check("reset_irq", {31'd0, bus32.gcd_irq}, 32'h0);
    bus_rd(0, ADDR_A, rd);      check("reset_a", rd, 32'h0);
    bus_rd(0, ADDR_B, rd);      check("reset_b", rd, 32'h0);
    bus_rd(0, ADDR_RESULT, rd); check("reset_result", rd, 32'h0);
    bus_rd(0, ADDR_CYCLES, rd); check("reset_cycles", rd, 32'h0);
    bus_wr(0, 3'd6, 32'hFFFF_FFFF);
    bus_wr(0, 3'd7, 32'hFFFF_FFFF);
    bus_rd(0, 3'd6, rd);        check("addr6_reads0", rd, 32'h0);
    bus_rd(0, 3'd7, rd);        check("addr7_reads0", rd, 32'h0);
    bus_rd(0, ADDR_A, rd);      check("addr67_no_alias", rd, 32'h0);

    // Vector table
    for (int i = 0; i < 8; i++) begin
      run_gcd(0, vecs[i].a, vecs[i].b, $sformatf("vec%0d", i), res, cyc);
      check($sformatf("vec%0d_result", i), res, vecs[i].res);
      check($sformatf("vec%0d_cycles", i), cyc, vecs[i].cyc);
      bus_rd(0, ADDR_STATUS, rd);
      check($sformatf("vec%0d_status", i), rd, 32'h3);
    end

    // Done and clear-done land on the same edge: done must stay set
    bus_wr(0, ADDR_A, 32'd5);
    bus_wr(0, ADDR_B, 32'd0);
    bus_wr(0, ADDR_CTRL, 32'h1);
    bus_wr(0, ADDR_CTRL, 32'h2);
    bus_rd(0, ADDR_STATUS, rd); check("done_vs_clear", rd, 32'h3);
    bus_wr(0, ADDR_CTRL, 32'h2);
    bus_rd(0, ADDR_STATUS, rd); check("clear_done", rd, 32'h1);

    // Operand writes during OP do not disturb the running computation
    bus_wr(0, ADDR_A, 32'd36);
    bus_wr(0, ADDR_B, 32'd24);
    bus_wr(0, ADDR_CTRL, 32'h1);
    bus_wr(0, ADDR_A, 32'd7);
    bus_wr(0, ADDR_B, 32'd5);
    wait_ready(0, "wr_during_op");
    bus_rd(0, ADDR_RESULT, rd); check("wr_during_op_result", rd, 32'd12);
    bus_rd(0, ADDR_CYCLES, rd); check("wr_during_op_cycles", rd, 32'd6);
    bus_rd(0, ADDR_A, rd);      check("wr_during_op_a", rd, 32'd7);
    bus_rd(0, ADDR_B, rd);      check("wr_during_op_b", rd, 32'd5);

    // Start while busy sets sticky err and is otherwise ignored
    bus_wr(0, ADDR_A, 32'd36);
    bus_wr(0, ADDR_B, 32'd24);
    bus_wr(0, ADDR_CTRL, 32'h1);
    bus_wr(0, ADDR_CTRL, 32'h1);
    wait_ready(0, "err");
    bus_rd(0, ADDR_RESULT, rd); check("err_result", rd, 32'd12);
    bus_rd(0, ADDR_CYCLES, rd); check("err_cycles", rd, 32'd6);
    bus_rd(0, ADDR_STATUS, rd); check("err_status", rd, 32'hB);
    bus_wr(0, ADDR_CTRL, 32'h8);
    bus_rd(0, ADDR_STATUS, rd); check("err_cleared", rd, 32'h3);

    // Interrupt follows done_flag when enabled
    bus_wr(0, ADDR_CTRL, 32'h6);
    bus_rd(0, ADDR_STATUS, rd); check("irq_en_status", rd, 32'h5);
    check("irq_low_before", {31'd0, bus32.gcd_irq}, 32'h0);
    bus_wr(0, ADDR_CTRL, 32'h5);
    bus_rd(0, ADDR_STATUS, rd); check("irq_busy_status", rd, 32'h4);
    check("irq_low_busy", {31'd0, bus32.gcd_irq}, 32'h0);
    wait_ready(0, "irq");
    bus_rd(0, ADDR_STATUS, rd); check("irq_done_status", rd, 32'h7);
    check("irq_high", {31'd0, bus32.gcd_irq}, 32'h1);
    bus_wr(0, ADDR_CTRL, 32'h6);
    bus_rd(0, ADDR_STATUS, rd); check("irq_cleared_status", rd, 32'h5);
    check("irq_cleared", {31'd0, bus32.gcd_irq}, 32'h0);

    // Reset pulse in the middle of a computation
    bus_wr(0, ADDR_CTRL, 32'h5);
    repeat (2) @(negedge clk);
    #2;
    reset_n = 1'b0;
    bus32.gcd_address = ADDR_STATUS;
    #1;
    check("rst_op_status_now", bus32.gcd_readdata, 32'h1);
    check("rst_op_irq_now", {31'd0, bus32.gcd_irq}, 32'h0);
    @(negedge clk);
    reset_n = 1'b1;
    bus_rd(0, ADDR_RESULT, rd); check("rst_op_result", rd, 32'h0);
    repeat (10) @(negedge clk);
    bus_rd(0, ADDR_STATUS, rd); check("rst_op_status", rd, 32'h1);
    bus_rd(0, ADDR_CYCLES, rd); check("rst_op_cycles", rd, 32'h0);
    check("rst_op_irq", {31'd0, bus32.gcd_irq}, 32'h0);

    // Narrow instance: operands truncated to W bits
    bus_wr(1, ADDR_A, 32'h1FF);
    bus_rd(1, ADDR_A, rd);      check("w8_a_trunc", rd, 32'hFF);
    run_gcd(1, 32'h1FF, 32'hFF, "w8", res, cyc);
    check("w8_result", res, 32'hFF);
    check("w8_cycles", cyc, 32'h1);

    // Random operands against the behavioural model
    for (int i = 0; i < 24; i++) begin
      if (i % 4 == 0) begin
        ra = $urandom();
        rb = $urandom();
      end else begin
        ra = $urandom_range(0, 5000) << $urandom_range(0, 6);
        rb = $urandom_range(0, 5000) << $urandom_range(0, 6);
      end
      exp_q.push_back(ref_gcd(ra, rb));
      exp_q.push_back(32'(ref_cycles(ra, rb)));
      run_gcd(0, ra, rb, $sformatf("rand%0d", i), res, cyc);
      check($sformatf("rand%0d_result(%0d,%0d)", i, ra, rb), res, exp_q.pop_front());
      check($sformatf("rand%0d_cycles(%0d,%0d)", i, ra, rb), cyc, exp_q.pop_front());
    end

    // ---------------- final report ----------------
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation still running, required finish");
    $fatal(1);
  end

endmodule

// File: doc/chu_avalon_gcdx.md
CHU_AVALON_GCDX -- requirements
Module: chu_avalon_gcdx

Interface
REQ-001 SHALL have parameter W, default 32, operand/result width, legal range 8..32.
REQ-002 SHALL have parameter CW, default 16, cycle-counter width, legal range 8..32.
REQ-003 SHALL have port clk  in  1  single clock; all state changes on its rising edge.
REQ-004 SHALL have port reset_n  in  1  reset, asynchronous, active-low.
REQ-005 SHALL have port gcd_address  in  3  Avalon-MM word address.
REQ-006 SHALL have ports gcd_chipselect, gcd_write, gcd_read  in  1 each  Avalon-MM strobes.
REQ-007 SHALL have port gcd_writedata  in  32  write data.
REQ-008 SHALL have port gcd_readdata  out  32  read data, zero wait states, zero-extended.
REQ-009 SHALL have port gcd_irq  out  1  level interrupt, equal to done_flag AND irq_en.

Function
REQ-010 Register map SHALL be: 0 A (R/W), 1 B (R/W), 2 CTRL (W), 3 STATUS (R), 4 RESULT (R), 5 CYCLES (R); addresses 6-7 SHALL read 0 and ignore writes.
REQ-011 Write acceptance SHALL be gcd_chipselect AND gcd_write; writes to A/B SHALL store gcd_writedata[W-1:0].
REQ-012 gcd_readdata SHALL be combinational from gcd_address; gcd_read only qualifies the access and has no side effect.
REQ-013 CTRL bits SHALL be: bit0 start, bit1 clear done_flag, bit2 irq_en (stored), bit3 clear err_flag.
REQ-014 STATUS SHALL be: bit0 ready, bit1 done_flag, bit2 irq_en, bit3 err_flag; other bits 0.
REQ-015 Engine SHALL have states IDLE and OP; ready = (state == IDLE).
REQ-016 Start in IDLE SHALL latch A and B into the engine, set n=0, clear done_flag, clear CYCLES, and enter OP next cycle.
REQ-017 Start while in OP SHALL be ignored and SHALL set err_flag (sticky).
REQ-018 Each OP cycle SHALL apply the first matching rule: a==0 -> result=b<<n, done; b==0 -> result=a<<n, done; a==b -> result=a<<n, done; both even -> a>>=1, b>>=1, n+=1; a even -> a>>=1; b even -> b>>=1; a>b -> a=a-b; else b=b-a.
REQ-019 On done the engine SHALL return to IDLE next cycle, load RESULT, and set done_flag.
REQ-020 CYCLES SHALL increment once per OP cycle, including the done cycle, and saturate at 2^CW-1.
REQ-021 Writes to A/B during OP SHALL be accepted and SHALL NOT affect the running computation.
REQ-022 done event and CTRL clear-done in the same cycle: done_flag SHALL end set.
REQ-023 RESULT SHALL hold its value until the next done; gcd(0,0) SHALL be 0.

Reset
REQ-024 reset_n low SHALL immediately force IDLE and clear A, B, RESULT, CYCLES, n, done_flag, err_flag and irq_en; gcd_irq SHALL be 0 and STATUS SHALL read 0x1.
REQ-025 Reset asserted during OP SHALL abort the computation without any done event.

Structure
REQ-026 Package chu_gcd_pkg SHALL hold the register addresses, CTRL/STATUS bit positions and engine state encoding.
REQ-027 Engine SHALL be sub-module chu_gcd_core (start, a_in, b_in, ready, done_tick, r); the top holds the bus decode, flags and counter.

Verification
REQ-028 A=36, B=24, start -> done after 6 OP cycles; RESULT=12, CYCLES=6, done_flag=1.
REQ-029 A=0, B=0, start -> done in 1 cycle; RESULT=0, CYCLES=1.
REQ-030 W=8: A=0x1FF written -> A reads 0xFF; B=0xFF, start -> RESULT=0xFF, CYCLES=1.
REQ-031 Start, then start again while ready=0 -> err_flag=1, RESULT of the first run unchanged; CTRL=0x8 -> err_flag=0.
REQ-032 CTRL=0x4, A=36, B=24, start -> gcd_irq rises with done_flag; CTRL=0x6 -> gcd_irq=0.
REQ-033 reset_n pulsed low during OP -> STATUS=0x1, RESULT=0, gcd_irq=0, no done_flag set.
